// File: rtl/alu_stream_unit.sv
// Registered, handshaked ALU stage with a running accumulator.
// Takes one operand pair in IDLE, computes it in EXEC, and holds the result in HOLD until the consumer takes it.
module alu_stream_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cb,
    output logic             err_op,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d, acc_q, acc_d;
    logic             zero_q, zero_d, cb_q, cb_d, err_q, err_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [WIDTH-1:0] exec_res, exec_acc;
    logic             exec_cb, exec_err;
    logic [WIDTH:0]   wide;

    // Datapath: evaluates the captured operation against the captured operands.
    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        exec_res = '0;
        exec_acc = acc_q;
        exec_cb  = 1'b0;
        exec_err = 1'b0;
        wide     = '0;
        case (op_q)
            4'd0:  exec_res = a_q & b_q;
            4'd1:  exec_res = a_q | b_q;
            4'd2:  exec_res = a_q ^ b_q;
            4'd3:  exec_res = ~a_q;
            4'd4:  exec_res = {a_q[WIDTH/2-1:0], b_q[WIDTH/2-1:0]};
            4'd5:  exec_res = a_q >> b_q[SHW-1:0];
            4'd6:  exec_res = {{(WIDTH-1){1'b0}}, &b_q};
            4'd7:  exec_res = (a_q > b_q) ? a_q : b_q;
            4'd8: begin
                wide     = {1'b0, a_q} - {1'b0, b_q};
                exec_res = wide[WIDTH-1:0];
                exec_cb  = wide[WIDTH];
            end
            4'd9:  exec_res = (a_q < b_q) ? a_q : b_q;
            4'd10: begin
                wide     = {1'b0, acc_q} + {1'b0, a_q};
                exec_res = wide[WIDTH-1:0];
                exec_acc = wide[WIDTH-1:0];
                exec_cb  = wide[WIDTH];
            end
            4'd11: exec_acc = '0;
            default: exec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        acc_d    = acc_q;
        zero_d   = zero_q;
        cb_d     = cb_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = exec_res;
                acc_d    = exec_acc;
                zero_d   = (exec_res == '0);
                cb_d     = exec_cb;
                err_d    = exec_err;
                state_d  = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs follow the next state, so they are registered yet never lag it.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            acc_q       <= '0;
            zero_q      <= 1'b0;
            cb_q        <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            acc_q       <= acc_d;
            zero_q      <= zero_d;
            cb_q        <= cb_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign cb        = cb_q;
    assign err_op    = err_q;
    assign acc       = acc_q;

endmodule
